// File: rtl/bp_pkg.sv
// Shared branch-predictor constants and 2-bit-style saturating counter helpers.
// Used by bp_updater and bp_cache so both agree on counter encoding.
package bp_pkg;

  localparam int BP_DWIDTH = 2;
  // Helpers work on a fixed maximum width; callers truncate to their DWIDTH.
  localparam int BP_MAXW   = 8;

  function automatic logic [BP_MAXW-1:0] bp_weak_taken(input int w);
    return BP_MAXW'(1 << (w - 1));
  endfunction

  function automatic logic [BP_MAXW-1:0] bp_weak_not_taken(input int w);
    return BP_MAXW'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [BP_MAXW-1:0] bp_sat_inc(input logic [BP_MAXW-1:0] v,
                                                    input int w);
    logic [BP_MAXW-1:0] top;
    top = BP_MAXW'((1 << w) - 1);
    return (v >= top) ? top : v + BP_MAXW'(1);
  endfunction

  function automatic logic [BP_MAXW-1:0] bp_sat_dec(input logic [BP_MAXW-1:0] v);
    return (v == '0) ? '0 : v - BP_MAXW'(1);
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO with combinational head; full/empty from wrap-bit pointers.
// Push is blocked only by full, independent of a same-cycle pop.
module bp_upd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/bp_updater.sv
// Branch-predictor update engine: queues resolved branches, reads the current
// counter through one cache port and writes back the saturated next value.
module bp_updater
  import bp_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = BP_DWIDTH,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [AWIDTH-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_hold,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  input  logic              rd_hit,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              wr_en,
  output logic              busy
);

  localparam int FW = AWIDTH + 1;

  function automatic logic [DWIDTH-1:0] next_ctr(input logic [DWIDTH-1:0] cur,
                                                 input logic hit,
                                                 input logic taken);
    logic [BP_MAXW-1:0] v;
    if (!hit)
      v = taken ? bp_weak_taken(DWIDTH) : bp_weak_not_taken(DWIDTH);
    else if (taken)
      v = bp_sat_inc(BP_MAXW'(cur), DWIDTH);
    else
      v = bp_sat_dec(BP_MAXW'(cur));
    return v[DWIDTH-1:0];
  endfunction

  logic [FW-1:0]     head_p0;
  logic [AWIDTH-1:0] head_pc_p0;
  logic              head_taken_p0;
  logic              full_p0;
  logic              empty_p0;
  logic              pop_p0;
  logic              fwd_p0;
  logic              hit_p0;
  logic [DWIDTH-1:0] cur_p0;
  logic [DWIDTH-1:0] next_p0;

  logic              vld_p1;
  logic [AWIDTH-1:0] wr_addr_p1;
  logic [DWIDTH-1:0] wr_data_p1;

  bp_upd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (upd_valid),
    .din   ({upd_pc, upd_taken}),
    .pop   (pop_p0),
    .head  (head_p0),
    .full  (full_p0),
    .empty (empty_p0)
  );

  // Stage p0: pop, forward from the pending write, compute next counter
  assign head_pc_p0    = head_p0[FW-1:1];
  assign head_taken_p0 = head_p0[0];
  assign pop_p0        = !empty_p0 && !upd_hold;

  // The pending write has not reached the cache yet, so it overrides the read.
  assign fwd_p0  = vld_p1 && (wr_addr_p1 == head_pc_p0);
  assign hit_p0  = fwd_p0 || rd_hit;
  assign cur_p0  = fwd_p0 ? wr_data_p1 : rd_data;
  assign next_p0 = next_ctr(cur_p0, hit_p0, head_taken_p0);

  // Stage p1: write register toward the cache
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= pop_p0;
      if (pop_p0) begin
        wr_addr_p1 <= head_pc_p0;
        wr_data_p1 <= next_p0;
      end
    end
  end

  assign upd_ready = !full_p0;
  assign rd_addr   = head_pc_p0;
  assign wr_addr   = wr_addr_p1;
  assign wr_data   = wr_data_p1;
  assign wr_en     = vld_p1;
  assign busy      = !empty_p0 || vld_p1;

endmodule
